// File: rtl/axi_prefetch_rd_pkg.sv
// Shared AXI constants and types for the instruction prefetch read master.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} fetch_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/axi_prefetch_rd_if.sv
// AXI read address/data channel bundle between the prefetcher and the ROM slave.
interface axi_prefetch_rd_if;
    logic        axi_ARVALID;
    logic        axi_ARREADY;
    logic [31:0] axi_AR;
    logic [7:0]  axi_ARLEN;
    logic [1:0]  axi_ARBURST;
    logic [31:0] axi_R;
    logic        axi_RVALID;
    logic        axi_RREADY;
    logic        axi_RLAST;

    modport master (
        output axi_ARVALID, axi_AR, axi_ARLEN, axi_ARBURST, axi_RREADY,
        input  axi_ARREADY, axi_R, axi_RVALID, axi_RLAST
    );

    modport slave (
        input  axi_ARVALID, axi_AR, axi_ARLEN, axi_ARBURST, axi_RREADY,
        output axi_ARREADY, axi_R, axi_RVALID, axi_RLAST
    );
endinterface

// File: rtl/axi_prefetch_rd_fifo.sv
// Synchronous word buffer; flush beats push, and push+pop is legal even when full.
module prefetch_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is masked while empty so stale storage never reaches the consumer.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_prefetch_rd.sv
// Prefetching AXI read master: streams INCR line bursts from a start address into a word FIFO.
module axi_prefetch_rd
    import axi_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        q_valid,
    input  logic        q_ready,
    output logic [31:0] q_data,
    output logic [31:0] q_addr,
    axi_prefetch_rd_if.master axi
);

    localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW     = $clog2(LINE_WORDS);
    localparam logic [31:0] STRIDE = 32'(4 * LINE_WORDS);

    fetch_state_t  state, state_nxt;
    logic [31:0]   fetch_ptr, beat_addr, ar_q, req_al;
    logic [BW-1:0] beat_cnt;
    logic          running, discard;
    logic          accept, ar_hs, rbeat, end_beat, has_room;
    logic          f_push, f_pop, f_full, f_empty;
    logic [CW-1:0] f_count;
    fifo_entry_t   f_din, f_dout;

    assign req_al   = {req_addr[31:2], 2'b00};
    assign accept   = req_valid & req_ready;
    assign ar_hs    = axi.axi_ARVALID & axi.axi_ARREADY;
    assign rbeat    = axi.axi_RVALID & axi.axi_RREADY;
    assign end_beat = rbeat & (axi.axi_RLAST | (beat_cnt == BW'(LINE_WORDS - 1)));
    assign has_room = (CW'(FIFO_DEPTH) - f_count) >= CW'(LINE_WORDS);

    // A beat landing in the redirect cycle belongs to the old stream and is dropped.
    assign f_push = rbeat & ~discard & ~accept;
    assign f_pop  = q_valid & q_ready & ~accept;
    assign f_din  = '{addr: beat_addr, data: axi.axi_R};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept || (running && !discard && has_room)) state_nxt = ADDR;
            ADDR: if (axi.axi_ARREADY) state_nxt = DATA;
            DATA: if (end_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state != ADDR);
        axi.axi_ARVALID = (state == ADDR);
        axi.axi_RREADY  = (state == DATA);
        axi.axi_AR      = ar_q;
        axi.axi_ARLEN   = 8'(LINE_WORDS - 1);
        axi.axi_ARBURST = AXI_BURST_INCR;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_ptr <= '0;
            beat_addr <= '0;
            ar_q      <= '0;
            beat_cnt  <= '0;
            running   <= 1'b0;
            discard   <= 1'b0;
        end else begin
            if (accept) begin
                fetch_ptr <= req_al;
                running   <= 1'b1;
            end else if (ar_hs) begin
                fetch_ptr <= fetch_ptr + STRIDE;
            end
            // Redirect from IDLE issues straight away so ARVALID appears one cycle after accept.
            if (state == IDLE && state_nxt == ADDR) ar_q <= accept ? req_al : fetch_ptr;
            if (ar_hs) begin
                beat_addr <= ar_q;
                beat_cnt  <= '0;
            end else if (rbeat) begin
                beat_addr <= beat_addr + 32'd4;
                beat_cnt  <= beat_cnt + BW'(1);
            end
            if (end_beat)                    discard <= 1'b0;
            else if (accept && state == DATA) discard <= 1'b1;
        end
    end

    prefetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (f_push),
        .din   (f_din),
        .pop   (f_pop),
        .flush (accept),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign q_valid = ~f_empty;
    assign q_data  = f_dout.data;
    assign q_addr  = f_dout.addr;

endmodule

// File: tb/tb_axi_prefetch_rd.sv
// Directed bench for axi_prefetch_rd against a single-cycle ROM returning data == address.
module tb_axi_prefetch_rd;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        q_ready = 1'b0;
    logic        req_ready, q_valid;
    logic [31:0] q_data, q_addr;
    logic        ar_ready_en = 1'b1;
    logic        s_busy = 1'b0;

    axi_prefetch_rd_if axi();

    axi_prefetch_rd #(.LINE_WORDS(4), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_data    (q_data),
        .q_addr    (q_addr),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] ar_log[$];
    logic [31:0] pa[$];
    logic [31:0] pd[$];
    int ab, pb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ROM slave: samples handshakes mid-cycle, updates just after the rising edge.
    assign axi.axi_ARREADY = ar_ready_en & ~s_busy;

    initial begin : slave
        logic        ar_hs, r_hs;
        logic [31:0] s_addr, ar_addr;
        int          s_left, ar_len;
        axi.axi_RVALID = 1'b0;
        axi.axi_R      = '0;
        axi.axi_RLAST  = 1'b0;
        s_addr = '0;
        s_left = 0;
        forever begin
            @(negedge clk);
            ar_hs   = axi.axi_ARVALID & axi.axi_ARREADY;
            r_hs    = axi.axi_RVALID & axi.axi_RREADY;
            ar_addr = axi.axi_AR;
            ar_len  = int'(axi.axi_ARLEN) + 1;
            if (ar_hs) ar_log.push_back(ar_addr);
            @(posedge clk);
            #1;
            if (!rstn) begin
                s_busy = 1'b0;
                axi.axi_RVALID = 1'b0;
                axi.axi_RLAST  = 1'b0;
            end else if (ar_hs) begin
                s_busy = 1'b1;
                s_addr = ar_addr;
                s_left = ar_len;
                axi.axi_RVALID = 1'b1;
                axi.axi_R      = s_addr;
                axi.axi_RLAST  = (s_left == 1);
            end else if (r_hs) begin
                s_left--;
                s_addr += 32'd4;
                if (s_left == 0) begin
                    s_busy = 1'b0;
                    axi.axi_RVALID = 1'b0;
                    axi.axi_RLAST  = 1'b0;
                end else begin
                    axi.axi_R     = s_addr;
                    axi.axi_RLAST = (s_left == 1);
                end
            end
        end
    end

    // Consumer view: a pop in a redirect cycle is void and not logged.
    always @(negedge clk) begin
        if (rstn && q_valid && q_ready && !(req_valid && req_ready)) begin
            pa.push_back(q_addr);
            pd.push_back(q_data);
        end
    end

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_arvalid"}, 32'(axi.axi_ARVALID), 32'd0);
        chk({pfx, "_rready"},  32'(axi.axi_RREADY),  32'd0);
        chk({pfx, "_ar"},      axi.axi_AR,           32'd0);
        chk({pfx, "_qvalid"},  32'(q_valid),         32'd0);
        chk({pfx, "_qdata"},   q_data,               32'd0);
        chk({pfx, "_qaddr"},   q_addr,               32'd0);
        chk({pfx, "_reqrdy"},  32'(req_ready),       32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 1'b0;
        q_ready = 1'b0;
        ar_ready_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic send_req(input logic [31:0] a);
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_pops(input string tag, input int n);
        for (int i = 0; i < 300; i++) begin
            if (pa.size() - pb >= n) break;
            @(negedge clk);
        end
        chk(tag, 32'(pa.size() - pb >= n), 32'd1);
    endtask

    task automatic wait_beats(input int n);
        int nb;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (axi.axi_RVALID && axi.axi_RREADY) nb++;
            if (nb == n) break;
        end
        chk("beat_wait", 32'(nb), 32'(n));
    endtask

    initial begin
        // Reset values, then sequential fetch from 0x10.
        #2;
        @(negedge clk);
        chk_reset_outputs("rst0");
        do_reset();
        q_ready = 1'b1;
        ab = ar_log.size();
        pb = pa.size();
        send_req(32'h10);
        @(negedge clk);
        chk("t1_arvalid_lat", 32'(axi.axi_ARVALID), 32'd1);
        chk("t1_ar0",         axi.axi_AR,           32'h10);
        chk("t1_arlen",       32'(axi.axi_ARLEN),   32'd3);
        chk("t1_arburst",     32'(axi.axi_ARBURST), 32'd1);
        wait_pops("t1_pops", 12);
        for (int i = 0; i < 12; i++) begin
            chk("t1_qaddr", pa[pb+i], 32'h10 + 32'(4*i));
            chk("t1_qdata", pd[pb+i], 32'h10 + 32'(4*i));
        end
        for (int i = 0; i < 3; i++) chk("t1_arseq", ar_log[ab+i], 32'h10 + 32'(16*i));

        // Back-pressure: two lines fill the buffer, third line waits for 4 free entries.
        do_reset();
        ab = ar_log.size();
        pb = pa.size();
        send_req(32'h0);
        repeat (40) @(negedge clk);
        chk("t2_ar_cnt2",  32'(ar_log.size() - ab), 32'd2);
        chk("t2_qvalid",   32'(q_valid),            32'd1);
        chk("t2_head",     q_addr,                  32'h0);
        @(posedge clk);
        #1 q_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 q_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_ar_hold",  32'(ar_log.size() - ab), 32'd2);
        chk("t2_pop3",     32'(pa.size() - pb),     32'd3);
        chk("t2_head3",    q_addr,                  32'hC);
        @(posedge clk);
        #1 q_ready = 1'b1;
        @(posedge clk);
        #1 q_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_ar_cnt3",  32'(ar_log.size() - ab), 32'd3);
        chk("t2_ar3",      ar_log[ab+2],            32'h20);
        q_ready = 1'b1;
        wait_pops("t2_pops", 16);
        for (int i = 0; i < 16; i++) chk("t2_qaddr", pa[pb+i], 32'(4*i));

        // Redirect during the second beat of a burst.
        do_reset();
        q_ready = 1'b1;
        ab = ar_log.size();
        pb = pa.size();
        send_req(32'h0);
        wait_beats(1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        @(negedge clk);
        chk("t3_reqrdy", 32'(req_ready), 32'd1);
        chk("t3_beat2",  axi.axi_R,      32'h4);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_pops("t3_pops", 4);
        chk("t3_ar0", ar_log[ab],   32'h0);
        chk("t3_ar1", ar_log[ab+1], 32'h100);
        for (int i = 0; i < 4; i++) begin
            chk("t3_qaddr", pa[pb+i], 32'h100 + 32'(4*i));
            chk("t3_qdata", pd[pb+i], 32'h100 + 32'(4*i));
        end

        // Request held while AR stalls: blocked until the address handshake completes.
        do_reset();
        q_ready = 1'b1;
        ar_ready_en = 1'b0;
        ab = ar_log.size();
        pb = pa.size();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h200;
        @(posedge clk);
        #1 req_addr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_reqrdy0", 32'(req_ready),       32'd0);
            chk("t4_arvalid", 32'(axi.axi_ARVALID), 32'd1);
            chk("t4_ar",      axi.axi_AR,           32'h200);
        end
        @(posedge clk);
        #1 ar_ready_en = 1'b1;
        @(negedge clk);
        chk("t4_hs_cycle", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("t4_accept",   32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_pops("t4_pops", 4);
        chk("t4_ar0", ar_log[ab],   32'h200);
        chk("t4_ar1", ar_log[ab+1], 32'h300);
        for (int i = 0; i < 4; i++) chk("t4_qaddr", pa[pb+i], 32'h300 + 32'(4*i));

        // Redirect coinciding with the RLAST beat.
        do_reset();
        q_ready = 1'b1;
        ab = ar_log.size();
        pb = pa.size();
        send_req(32'h0);
        wait_beats(3);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h400;
        @(negedge clk);
        chk("t5_rlast", 32'(axi.axi_RLAST), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t5_idle_rready",  32'(axi.axi_RREADY),  32'd0);
        chk("t5_idle_arvalid", 32'(axi.axi_ARVALID), 32'd0);
        wait_pops("t5_pops", 6);
        chk("t5_ar1", ar_log[ab+1], 32'h400);
        chk("t5_q0",  pa[pb],       32'h0);
        chk("t5_q1",  pa[pb+1],     32'h4);
        chk("t5_q2",  pa[pb+2],     32'h400);
        chk("t5_q3",  pa[pb+3],     32'h404);

        // Reset mid-burst, then a clean fetch from 0x40.
        do_reset();
        q_ready = 1'b1;
        send_req(32'h0);
        wait_beats(2);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst1");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        ab = ar_log.size();
        pb = pa.size();
        send_req(32'h40);
        wait_pops("t6_pops", 4);
        chk("t6_ar0", ar_log[ab], 32'h40);
        for (int i = 0; i < 4; i++) begin
            chk("t6_qaddr", pa[pb+i], 32'h40 + 32'(4*i));
            chk("t6_qdata", pd[pb+i], 32'h40 + 32'(4*i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_prefetch_rd.md
Name: axi_prefetch_rd

Overview:
- AXI read master that sits directly upstream of the boot ROM / memory slave.
- Turns a single "start fetching at address X" request into back-to-back INCR bursts.
- Buffers the returned words with their addresses in a FIFO and hands them to the CPU fetch unit over a valid/ready stream.
- Supports redirect (branch/flush) at any time except while an AR handshake is pending.

Parameters:
- LINE_WORDS, 4, words per burst (ARLEN = LINE_WORDS-1); power of two, 2..16.
- FIFO_DEPTH, 8, entries in the word buffer; power of two, >= LINE_WORDS.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  redirect/start request
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_addr  in  32  start byte address; bits [1:0] ignored (treated as 00)
- q_valid  out  1  fetched word available
- q_ready  in  1  consumer takes word
- q_data  out  32  fetched word
- q_addr  out  32  byte address of q_data
- axi_ARVALID  out  1  address valid
- axi_ARREADY  in  1  address accepted
- axi_AR  out  32  burst start address
- axi_ARLEN  out  8  constant LINE_WORDS-1
- axi_ARBURST  out  2  constant 2'b01 (INCR)
- axi_R  in  32  read data
- axi_RVALID  in  1  read data valid
- axi_RREADY  out  1  read data ready
- axi_RLAST  in  1  last beat of burst

Behaviour:
- Reset, asynchronous: clk and reset are clk / rstn (asynchronous, active-low); all state is cleared on rstn low.
  - Reset values: state=IDLE, running=0, fetch_ptr=0, discard=0, FIFO empty.
  - Output reset values: axi_ARVALID=0, axi_RREADY=0, axi_AR=0, q_valid=0, q_data=0, q_addr=0, req_ready=1.
  - Reset mid-burst abandons the burst; the slave is reset by the same rstn.
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR when running=1, discard=0, and FIFO free entries >= LINE_WORDS. Entering ADDR registers axi_ARVALID=1 and axi_AR=fetch_ptr.
  - ADDR: hold axi_ARVALID and axi_AR stable until axi_ARREADY. On the handshake, drop ARVALID, set the beat address to fetch_ptr, advance fetch_ptr += 4*LINE_WORDS (mod 2^32), and go to DATA.
  - DATA: axi_RREADY=1 continuously (space was reserved before issue).
    - Each cycle with RVALID & RREADY: if discard=0, push {beat_addr, axi_R} into the FIFO. beat_addr += 4 on every beat, pushed or not.
    - Beat with RLAST -> IDLE, discard cleared.
    - Burst length is counted; a beat with RLAST before LINE_WORDS beats still ends the burst.
- req_ready = (state != ADDR). AR must not be withdrawn before ARREADY.
- Request accept (req_valid & req_ready):
  - FIFO flushed in the same cycle; any pop that cycle is void.
  - fetch_ptr = {req_addr[31:2], 2'b00}; running=1.
  - If in DATA: discard=1, so the remaining beats, including the one in the same cycle, are dropped until RLAST.
- Simultaneous accept and RLAST: that beat is dropped, FSM goes to IDLE, discard ends 0, and the next burst starts at the new address.
- Stream side:
  - q_valid=1 whenever the FIFO is non-empty; q_data/q_addr show the head entry.
  - Pop on q_valid & q_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty.
- Latency, with a single-cycle slave, from req accept at cycle 0:
  - ARVALID high in cycle 1.
  - First word pushed the cycle the first RVALID handshake completes.
  - q_valid rises the following cycle (FIFO registered).
- FIFO full with the FSM in IDLE: no new AR issued. Overflow cannot occur.
- Address wrap: fetch_ptr and beat_addr wrap modulo 2^32. There is no 4 KB boundary check; the slaves in this design decode at most 1 KB.
- Free-entry check uses the current count: FIFO_DEPTH - count >= LINE_WORDS.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_FIXED / AXI_BURST_INCR / AXI_BURST_WRAP constants.
  - fetch_state_t enum {IDLE, ADDR, DATA}.
  - typedef of the FIFO entry {addr[31:0], data[31:0]}.
- One sub-module, prefetch_fifo:
  - Synchronous FIFO parameterised by DEPTH and width 64.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push in the same cycle.

Test Plan:
- Reset, then req 0x0000_0010, q_ready=1, ROM preloaded with word value = address -> q stream 0x10, 0x14, 0x18, ... with q_addr matching; AR sequence 0x10, 0x20, 0x30; ARLEN=3, ARBURST=01.
- q_ready=0 after req 0x0 -> exactly 8 words buffered; no third AR issued until at least 4 are popped.
- Redirect to 0x100 during the 2nd beat of a burst -> remaining 2 beats discarded; next AR=0x100; first q word addr 0x100; no stale addr appears.
- req held high while ARVALID=1 and ARREADY held low 5 cycles -> req_ready=0 throughout; axi_AR is stable; the request is accepted the cycle after ARREADY.
- Redirect in the same cycle as the RLAST beat -> that beat is dropped; FSM is in IDLE next cycle; the following AR is the new address.
- Assert rstn low mid-DATA, release, req 0x40 -> all outputs at reset values during reset; clean fetch from 0x40 afterward.
